// File: rtl/puf_crp_controller.sv
// Arbiter-PUF initiator: LFSR challenges, VOTES launches each, majority-voted byte out.
// Latency 2*SETTLE*VOTES cycles from challenge change to out_valid; EMIT holds until out_ready.
module puf_crp_controller #(
    parameter int C_LENGTH = 8,
    parameter int R_WIDTH  = 7,
    parameter int VOTES    = 5,
    parameter int SETTLE   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [C_LENGTH-1:0] seed,
    input  logic [7:0]          num_crp,
    output logic                busy,
    output logic                done,
    output logic [C_LENGTH-1:0] puf_challenge,
    output logic                puf_pulse,
    input  logic [R_WIDTH-1:0]  puf_response,
    output logic [7:0]          out_data,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] PH_LO = 3'd1;
    localparam logic [2:0] PH_HI = 3'd2;
    localparam logic [2:0] EMIT  = 3'd3;
    localparam logic [2:0] NEXT  = 3'd4;

    logic [2:0]                 state;
    logic [7:0]                 cnt;
    logic [3:0]                 vote_idx;
    logic [7:0]                 remaining;
    logic [R_WIDTH-1:0][3:0]    ones;
    logic [R_WIDTH-1:0][3:0]    ones_nxt;
    logic [R_WIDTH-1:0]         first_rsp;
    logic [R_WIDTH-1:0]         maj;
    logic                       any_diff;
    logic                       any_diff_nxt;
    logic                       phase_end;
    logic                       lfsr_fb;

    assign phase_end = (cnt == 8'(SETTLE - 1));
    assign lfsr_fb   = puf_challenge[7] ^ puf_challenge[5] ^ puf_challenge[4] ^ puf_challenge[3];

    // Vote totals including the sample being taken this cycle, so EMIT sees all VOTES.
    always_comb begin
        ones_nxt     = ones;
        maj          = '0;
        any_diff_nxt = any_diff;
        for (int i = 0; i < R_WIDTH; i++) begin
            ones_nxt[i] = ones[i] + 4'(puf_response[i]);
            maj[i]      = (ones_nxt[i] > 4'(VOTES / 2));
        end
        if ((vote_idx != 4'd0) && (puf_response != first_rsp))
            any_diff_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            vote_idx      <= '0;
            remaining     <= '0;
            ones          <= '0;
            first_rsp     <= '0;
            any_diff      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            puf_challenge <= '0;
            puf_pulse     <= 1'b0;
            out_data      <= '0;
            out_valid     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && (num_crp != 8'd0)) begin
                        puf_challenge <= (seed == '0) ? C_LENGTH'(1) : seed;
                        remaining     <= num_crp;
                        busy          <= 1'b1;
                        vote_idx      <= '0;
                        ones          <= '0;
                        any_diff      <= 1'b0;
                        cnt           <= '0;
                        state         <= PH_LO;
                    end
                end
                PH_LO: begin
                    if (phase_end) begin
                        cnt       <= '0;
                        puf_pulse <= 1'b1;
                        state     <= PH_HI;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                PH_HI: begin
                    if (phase_end) begin
                        cnt       <= '0;
                        puf_pulse <= 1'b0;
                        ones      <= ones_nxt;
                        any_diff  <= any_diff_nxt;
                        if (vote_idx == 4'd0)
                            first_rsp <= puf_response;
                        if (vote_idx < 4'(VOTES - 1)) begin
                            vote_idx <= vote_idx + 4'd1;
                            state    <= PH_LO;
                        end else begin
                            out_data  <= {~any_diff_nxt, maj};
                            out_valid <= 1'b1;
                            state     <= EMIT;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= NEXT;
                    end
                end
                NEXT: begin
                    remaining <= remaining - 8'd1;
                    if (remaining == 8'd1) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        puf_challenge <= {puf_challenge[C_LENGTH-2:0], lfsr_fb};
                        ones          <= '0;
                        any_diff      <= 1'b0;
                        vote_idx      <= '0;
                        cnt           <= '0;
                        state         <= PH_LO;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_crp_controller.sv
// Directed bench for puf_crp_controller: timing, voting, LFSR sequence, backpressure, resets.
module tb_puf_crp_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] seed;
    logic [7:0] num_crp;
    logic       busy;
    logic       done;
    logic [7:0] puf_challenge;
    logic       puf_pulse;
    logic [6:0] puf_response;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    int checks = 0;
    int errors = 0;

    logic [6:0] resp_pat [0:4];
    logic [7:0] ch_log   [0:7];
    logic [7:0] dat_log  [0:7];
    int         hs_cnt;
    int         done_cnt;

    always #5 clk = ~clk;

    puf_crp_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .seed          (seed),
        .num_crp       (num_crp),
        .busy          (busy),
        .done          (done),
        .puf_challenge (puf_challenge),
        .puf_pulse     (puf_pulse),
        .puf_response  (puf_response),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench at the negedge inside the first PH_LO cycle.
    task automatic launch(input logic [7:0] s, input logic [7:0] n);
        seed    = s;
        num_crp = n;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Runs until done (plus a few cycles), feeding resp_pat per launch edge.
    task automatic collect(input int budget);
        int   pidx;
        int   post;
        logic prev;
        hs_cnt   = 0;
        done_cnt = 0;
        pidx     = 0;
        post     = -1;
        prev     = puf_pulse;
        for (int c = 0; c < budget && post != 0; c++) begin
            if (puf_pulse && !prev) begin
                puf_response = resp_pat[pidx % 5];
                pidx++;
            end
            prev = puf_pulse;
            if (out_valid && out_ready) begin
                if (hs_cnt < 8) begin
                    ch_log[hs_cnt]  = puf_challenge;
                    dat_log[hs_cnt] = out_data;
                end
                hs_cnt++;
            end
            if (done) begin
                done_cnt++;
                if (post < 0) post = 4;
            end
            if (post > 0) post--;
            @(negedge clk);
        end
        if (post != 0) chk("collect_timeout", 32'd0, 32'd1);
    endtask

    task automatic set_pat(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c,
                           input logic [6:0] d, input logic [6:0] e);
        resp_pat[0] = a; resp_pat[1] = b; resp_pat[2] = c; resp_pat[3] = d; resp_pat[4] = e;
    endtask

    initial begin
        int         cyc;
        int         hi_cycles;
        int         rises;
        int         bad;
        logic       prev;
        logic [7:0] held_dat;
        logic [7:0] held_ch;

        rst_n        = 1'b0;
        start        = 1'b1;
        seed         = 8'h33;
        num_crp      = 8'd5;
        puf_response = '0;
        out_ready    = 1'b1;

        // Reset, with start asserted throughout.
        repeat (2) @(negedge clk);
        chk("rst_busy",      32'(busy),          32'd0);
        chk("rst_done",      32'(done),          32'd0);
        chk("rst_valid",     32'(out_valid),     32'd0);
        chk("rst_pulse",     32'(puf_pulse),     32'd0);
        chk("rst_challenge", 32'(puf_challenge), 32'd0);
        chk("rst_data",      32'(out_data),      32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Single challenge, constant response 0x55.
        puf_response = 7'h55;
        launch(8'h01, 8'd1);
        chk("t2_busy",      32'(busy),          32'd1);
        chk("t2_challenge", 32'(puf_challenge), 32'h01);
        cyc = 0; hi_cycles = 0; rises = 0; prev = puf_pulse;
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (puf_pulse) hi_cycles++;
            if (puf_pulse && !prev) rises++;
            prev = puf_pulse;
        end
        chk("t2_latency",   32'(cyc),       32'd40);
        chk("t2_hi_cycles", 32'(hi_cycles), 32'd20);
        chk("t2_pulses",    32'(rises),     32'd5);
        chk("t2_data",      32'(out_data),  32'hD5);
        chk("t2_pulse_emit", 32'(puf_pulse), 32'd0);
        @(negedge clk);
        chk("t2_valid_drop", 32'(out_valid), 32'd0);
        chk("t2_done_early", 32'(done),      32'd0);
        @(negedge clk);
        chk("t2_done",       32'(done),      32'd1);
        chk("t2_busy_end",   32'(busy),      32'd0);
        @(negedge clk);
        chk("t2_done_width", 32'(done),      32'd0);
        chk("t2_ch_hold",    32'(puf_challenge), 32'h01);

        // Three challenges walk the LFSR 01 -> 02 -> 04.
        set_pat(7'h2A, 7'h2A, 7'h2A, 7'h2A, 7'h2A);
        launch(8'h01, 8'd3);
        collect(1000);
        chk("t3_handshakes", 32'(hs_cnt),   32'd3);
        chk("t3_dones",      32'(done_cnt), 32'd1);
        chk("t3_ch0",        32'(ch_log[0]), 32'h01);
        chk("t3_ch1",        32'(ch_log[1]), 32'h02);
        chk("t3_ch2",        32'(ch_log[2]), 32'h04);
        chk("t3_dat2",       32'(dat_log[2]), 32'hAA);

        // Noisy bit 0: majority wins, unanimity lost.
        set_pat(7'h01, 7'h01, 7'h00, 7'h01, 7'h00);
        launch(8'h01, 8'd1);
        collect(500);
        chk("t4_noise_a", 32'(dat_log[0]), 32'h01);
        set_pat(7'h00, 7'h00, 7'h01, 7'h00, 7'h01);
        launch(8'h01, 8'd1);
        collect(500);
        chk("t4_noise_b", 32'(dat_log[0]), 32'h00);

        // Backpressure held for 10 cycles in EMIT.
        puf_response = 7'h13;
        out_ready    = 1'b0;
        launch(8'h5A, 8'd1);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("t5_reach_emit", 32'(out_valid), 32'd1);
        held_dat = out_data;
        held_ch  = puf_challenge;
        chk("t5_data", 32'(held_dat), 32'h93);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            puf_response = 7'(i);
            @(negedge clk);
            if (!out_valid || out_data !== held_dat || puf_pulse || puf_challenge !== held_ch)
                bad++;
        end
        chk("t5_hold", 32'(bad), 32'd0);
        chk("t5_challenge", 32'(held_ch), 32'h5A);
        out_ready = 1'b1;
        @(negedge clk);
        chk("t5_accept", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("t5_done", 32'(done), 32'd1);
        @(negedge clk);

        // Zero seed maps to 0x01.
        launch(8'h00, 8'd1);
        chk("t6_seed0", 32'(puf_challenge), 32'h01);
        set_pat(7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
        collect(500);

        // num_crp = 0 ignores start.
        launch(8'h77, 8'd0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (busy) bad++;
            @(negedge clk);
        end
        chk("t6_num0_busy", 32'(bad), 32'd0);

        // Reset during the high phase.
        launch(8'h01, 8'd2);
        repeat (5) @(negedge clk);
        chk("t6_in_hi", 32'(puf_pulse), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_pulse", 32'(puf_pulse),     32'd0);
        chk("t6_rst_busy",  32'(busy),          32'd0);
        chk("t6_rst_ch",    32'(puf_challenge), 32'd0);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            if (done || busy || puf_pulse) bad++;
            @(negedge clk);
        end
        chk("t6_no_done", 32'(bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/puf_crp_controller.md
Name: puf_crp_controller

Overview:
- Initiator side of the arbiter-PUF challenge/response interface.
- Generates challenges from an LFSR and launches `puf_pulse` edges into the PUF array.
- Samples the 7-bit response after each launch and applies temporal majority voting over repeated evaluations.
- Streams one stabilised response byte per challenge over a valid/ready output port to downstream logic.

Parameters:
- C_LENGTH, 8, challenge width (mux-chain length).
- R_WIDTH, 7, response width (parallel PUF instances).
- VOTES, 5, evaluations per challenge; odd, range 1..15.
- SETTLE, 4, cycles per pulse phase (low and high); range 2..255.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle request to begin a run.
- seed  in  C_LENGTH  initial LFSR value; 0 is replaced by 8'h01.
- num_crp  in  8  number of challenges per run; 0 means ignore start.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse after the last byte is accepted.
- puf_challenge  out  C_LENGTH  challenge to the PUF; changes only while puf_pulse=0.
- puf_pulse  out  1  launch signal to the PUF.
- puf_response  in  R_WIDTH  PUF arbiter outputs.
- out_data  out  8  {unanimous, majority[R_WIDTH-1:0]}.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.

Behaviour:
- Reset, sampled on a clk edge with rst_n=0: FSM→IDLE; busy, done, puf_pulse, out_valid = 0; puf_challenge, out_data = 0; vote counters cleared. Reset mid-run aborts immediately; no done is issued.
- States: IDLE, PH_LO, PH_HI, EMIT, NEXT.
- IDLE:
  - start=1 and num_crp≠0 → latch lfsr = (seed==0 ? 8'h01 : seed) and remaining=num_crp.
  - puf_challenge=lfsr is driven from the next cycle; busy=1 from the next cycle.
  - vote_idx=0, counters cleared; →PH_LO.
  - start with num_crp=0: no effect.
- PH_LO: puf_pulse=0 for SETTLE cycles, then →PH_HI.
- PH_HI:
  - puf_pulse=1 for SETTLE cycles.
  - On the last cycle, sample puf_response; per bit: ones[i] += response[i] (counter width 4).
  - Track any_diff: set if the current sample ≠ the first sample of this challenge.
  - If vote_idx<VOTES-1: vote_idx++, →PH_LO. Otherwise →EMIT.
  - puf_pulse returns to 0 on PH_HI exit.
- EMIT:
  - out_data[i] = (ones[i] > VOTES/2) for i<R_WIDTH; out_data[7] = ~any_diff.
  - out_valid=1; out_data, puf_challenge and puf_pulse=0 are held stable until out_valid & out_ready.
  - On handshake: out_valid=0 next cycle, →NEXT.
- NEXT:
  - remaining-- (8-bit).
  - If it reaches 0: done=1 for one cycle, busy=0, →IDLE. puf_challenge holds its last value.
  - Otherwise advance the LFSR: fb = c[7]^c[5]^c[4]^c[3]; c <= {c[6:0], fb} (x^8+x^6+x^5+x^4+1, maximal, never reaches 0). Clear counters and any_diff, vote_idx=0, →PH_LO.
- Timing per challenge:
  - The first PH_LO guarantees ≥SETTLE cycles of challenge settling before the launch edge.
  - Latency from challenge change to out_valid = 2·SETTLE·VOTES cycles.
- start while busy is ignored. out_ready while out_valid=0 is ignored.
- num_crp=255 produces 255 bytes; the LFSR wrap (period 255) is permitted.

Test Plan:
1. Hold rst_n=0 for 2 cycles → busy=done=out_valid=puf_pulse=0, puf_challenge=0; start during reset is ignored.
2. seed=8'h01, num_crp=1, puf_response=7'h55, out_ready=1:
   - puf_challenge=8'h01.
   - 5 pulses of 4 cycles low / 4 cycles high.
   - out_valid after 40 cycles with out_data=8'hD5.
   - done pulses 2 cycles after the handshake; busy returns to 0.
3. seed=8'h01, num_crp=3 → challenges 8'h01, 8'h02, 8'h04 in order; exactly 3 handshakes; one done pulse.
4. Noise: puf_response[0] = 1,1,0,1,0 across the five samples, other bits 0 → out_data=8'h01 (majority 1, unanimous 0). Pattern 0,0,1,0,1 → 8'h00.
5. Backpressure: out_ready=0 for 10 cycles in EMIT → out_valid and out_data held, no puf_pulse activity, challenge unchanged; accepted on the first ready cycle.
6. Edge cases:
   - seed=0 → first challenge 8'h01.
   - start with num_crp=0 → busy stays 0.
   - rst_n=0 mid-PH_HI → next cycle IDLE with puf_pulse=0 and no done.
